stream_in_packer: RTL and testbench

- Host-side input stage that feeds the cgra datapath.
- Accepts a narrow valid/ready word stream from the host and packs the words into DATA_WIDTH-bit lines.
- Buffers the lines in a first-word-fall-through FIFO and presents them on the cgra read interface (available_read / req_rd_data / rd_data).
- An in_last marker flushes a partial line, zero-padded.

---
 rtl/stream_in_pkg.sv | 31 +++
 rtl/stream_in_packer_sync_fifo_fwft.sv | 90 +++++++++
 rtl/stream_in_packer.sv | 101 ++++++++++
 tb/tb_stream_in_packer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_in_pkg.sv
// Shared constants and width helpers for the host stream input stage.
package stream_in_pkg;

  localparam int DEF_DATA_WIDTH = 512;
  localparam int DEF_IN_WIDTH   = 64;
  localparam int DEF_DEPTH      = 16;

  // Host words per cgra line.
  function automatic int calc_ratio(input int data_w, input int in_w);
    return data_w / in_w;
  endfunction

  // Word index width; a one-word line still needs a 1-bit index.
  function automatic int idx_width(input int ratio);
    if (ratio > 1) begin
      return $clog2(ratio);
    end else begin
      return 1;
    end
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DEF_RATIO = calc_ratio(DEF_DATA_WIDTH, DEF_IN_WIDTH);
  localparam int DEF_IDX_W = idx_width(DEF_RATIO);
  localparam int DEF_PTR_W = ptr_width(DEF_DEPTH);
  localparam int DEF_CNT_W = DEF_PTR_W + 1;

endpackage

// File: rtl/stream_in_packer_sync_fifo_fwft.sv
// First-word-fall-through line FIFO: head_data shows the oldest entry while not empty.
module sync_fifo_fwft
  import stream_in_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_empty;
  logic             w_full;

  assign w_empty   = (r_count == {CNT_W{1'b0}});
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_push_ok = push & ~w_full;
  assign w_pop_ok  = pop & ~w_empty;

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // Occupancy; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation, forced to zero when nothing is buffered.
  always_comb begin
    head_data = {WIDTH{1'b0}};
    if (!w_empty) begin
      head_data = r_mem[r_rd_ptr];
    end else begin
      head_data = {WIDTH{1'b0}};
    end
  end

  assign empty = w_empty;
  assign full  = w_full;
  assign count = r_count;

endmodule

// File: rtl/stream_in_packer.sv
// Packs host words little-endian into cgra lines and buffers them for the cgra read port.
module stream_in_packer
  import stream_in_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  localparam int RATIO = calc_ratio(DATA_WIDTH, IN_WIDTH),
  localparam int IDX_W = idx_width(RATIO),
  localparam int CNT_W = ptr_width(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_last,
  output logic                  available_read,
  input  logic                  req_rd_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      level,
  output logic                  underflow
);

  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_partial;
  logic                  r_underflow;
  logic [DATA_WIDTH-1:0] w_line;
  logic [DATA_WIDTH-1:0] w_head;
  logic [CNT_W-1:0]      w_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_commit;

  assign w_accept = in_valid & ~w_full;
  assign w_commit = w_accept & ((r_idx == IDX_W'(RATIO - 1)) | in_last);

  // Line as it would look with the current word dropped into slot r_idx.
  always_comb begin
    w_line = r_partial;
    for (int k = 0; k < RATIO; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_line[k*IN_WIDTH +: IN_WIDTH] = in_data;
      end else begin
        w_line[k*IN_WIDTH +: IN_WIDTH] = r_partial[k*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  // Partial line; cleared on commit so unfilled upper slots reach the FIFO as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx     <= {IDX_W{1'b0}};
      r_partial <= {DATA_WIDTH{1'b0}};
    end else if (w_commit) begin
      r_idx     <= {IDX_W{1'b0}};
      r_partial <= {DATA_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_idx     <= r_idx + IDX_W'(1);
      r_partial <= w_line;
    end else begin
      r_idx     <= r_idx;
      r_partial <= r_partial;
    end
  end

  // Sticky underflow: a read request against an empty FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_underflow <= 1'b0;
    end else if (req_rd_data && w_empty) begin
      r_underflow <= 1'b1;
    end else begin
      r_underflow <= r_underflow;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_commit),
    .push_data (w_line),
    .pop       (req_rd_data),
    .head_data (w_head),
    .empty     (w_empty),
    .full      (w_full),
    .count     (w_count)
  );

  // Flow control comes from the registered count only, never from req_rd_data.
  assign in_ready       = ~w_full;
  assign available_read = ~w_empty;
  assign rd_data        = w_head;
  assign level          = w_count;
  assign underflow      = r_underflow;

endmodule

// File: tb/tb_stream_in_packer.sv
// Directed self-checking bench for stream_in_packer at default parameters.
module tb_stream_in_packer;

  localparam int DW    = 512;
  localparam int IW    = 64;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          available_read;
  logic          req_rd_data = 1'b0;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] level;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_in_packer #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .available_read(available_read),
    .req_rd_data(req_rd_data), .rd_data(rd_data), .level(level),
    .underflow(underflow)
  );

  function automatic logic [DW-1:0] mk(input logic [IW-1:0] base, input int n);
    logic [DW-1:0] l;
    l = '0;
    for (int k = 0; k < n; k++) l[k*IW +: IW] = base + IW'(k);
    return l;
  endfunction

  task automatic push_word(input logic [IW-1:0] d, input logic last);
    int waited;
    waited = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (in_ready !== 1'b1 && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic push_line(input logic [IW-1:0] base, input int n, input logic last);
    for (int k = 0; k < n; k++) push_word(base + IW'(k), last && (k == n - 1));
  endtask

  task automatic pop_one();
    req_rd_data = 1'b1;
    @(posedge clk); #1;
    req_rd_data = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (available_read !== 1'b0) begin errors++; $display("FAIL rst_avail: got %b want 0", available_read); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", level); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst_underflow: got %b want 0", underflow); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || available_read !== 1'b0) begin
      errors++; $display("FAIL post_rst: in_ready=%b avail=%b want 1/0", in_ready, available_read);
    end
  endtask

  task automatic test_full_line();
    logic [DW-1:0] exp;
    push_line(64'h0, 7, 1'b0);
    checks++; if (available_read !== 1'b0) begin errors++; $display("FAIL partial_not_visible: avail=%b want 0", available_read); end
    push_word(64'h7, 1'b0);
    exp = mk(64'h0, 8);
    checks++; if (available_read !== 1'b1) begin errors++; $display("FAIL line_avail: got %b want 1", available_read); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL line_level: got %0d want 1", level); end
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL line_data: got %h want %h", rd_data, exp); end
    pop_one();
    checks++; if (available_read !== 1'b0 || level !== 5'd0) begin
      errors++; $display("FAIL line_pop: avail=%b level=%0d want 0/0", available_read, level);
    end
  endtask

  task automatic test_last_flush();
    logic [DW-1:0] exp;
    push_line(64'hA, 3, 1'b1);
    exp = mk(64'hA, 3);
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL flush_data: got %h want %h", rd_data, exp); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL flush_level: got %0d want 1", level); end
    pop_one();
    push_line(64'h100, 8, 1'b0);
    exp = mk(64'h100, 8);
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL after_flush_line: got %h want %h", rd_data, exp); end
    pop_one();
  endtask

  task automatic test_full_and_wrap();
    logic [DW-1:0] exp;
    for (int i = 0; i < DEPTH; i++) push_line(IW'(i * 256), 8, 1'b0);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d want 16", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b1; in_data = 64'hDEAD; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_stall_level: got %0d want 16", level); end
    exp = mk(64'h0, 8);
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL full_head: got %h want %h", rd_data, exp); end
    pop_one();
    checks++; if (level !== 5'd15 || in_ready !== 1'b1) begin
      errors++; $display("FAIL pop_from_full: level=%0d in_ready=%b want 15/1", level, in_ready);
    end
    for (int i = 1; i < DEPTH; i++) begin
      exp = mk(IW'(i * 256), 8);
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL drain_order_%0d: got %h want %h", i, rd_data, exp); end
      pop_one();
    end
    for (int i = 0; i < 40; i++) begin
      push_line(IW'(32'h1000 + i * 16), 8, 1'b0);
      exp = mk(IW'(32'h1000 + i * 16), 8);
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL wrap_%0d: got %h want %h", i, rd_data, exp); end
      pop_one();
    end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL wrap_level: got %0d want 0", level); end
  endtask

  task automatic test_commit_pop();
    logic [DW-1:0] exp;
    for (int i = 0; i < 5; i++) push_line(IW'(32'h50 + i), 1, 1'b1);
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL cp_level_pre: got %0d want 5", level); end
    push_line(64'h700, 7, 1'b0);
    in_valid = 1'b1; in_data = 64'h707; in_last = 1'b0; req_rd_data = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; req_rd_data = 1'b0;
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL cp_level: got %0d want 5", level); end
    for (int i = 1; i < 5; i++) begin
      exp = mk(IW'(32'h50 + i), 1);
      checks++; if (rd_data !== exp) begin errors++; $display("FAIL cp_order_%0d: got %h want %h", i, rd_data, exp); end
      pop_one();
    end
    exp = mk(64'h700, 8);
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL cp_tail: got %h want %h", rd_data, exp); end
    pop_one();
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL cp_level_end: got %0d want 0", level); end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] exp;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_pre: got %b want 0", underflow); end
    pop_one();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b want 1", underflow); end
    checks++; if (level !== 5'd0 || available_read !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL uf_state: level=%0d avail=%b in_ready=%b want 0/0/1", level, available_read, in_ready);
    end
    push_line(64'h900, 2, 1'b1);
    exp = mk(64'h900, 2);
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL uf_traffic: got %h want %h", rd_data, exp); end
    pop_one();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", underflow); end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] exp;
    for (int i = 0; i < 3; i++) push_line(IW'(32'hA0 + i), 1, 1'b1);
    push_line(64'hB00, 4, 1'b0);
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL ar_level_pre: got %0d want 3", level); end
    #3 rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
    checks++; if (available_read !== 1'b0) begin errors++; $display("FAIL ar_avail: got %b want 0", available_read); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL ar_level: got %0d want 0", level); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL ar_rd_data: got %h want 0", rd_data); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL ar_underflow: got %b want 0", underflow); end
    @(posedge clk); #1; rst = 1'b1;
    push_line(64'hC00, 8, 1'b0);
    exp = mk(64'hC00, 8);
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL ar_clean_line: got %h want %h", rd_data, exp); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL ar_level_post: got %0d want 1", level); end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_last_flush();
    test_full_and_wrap();
    test_commit_pop();
    test_underflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
